// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_W_DEF);

endpackage

// File: rtl/data_mem_ws_if.sv
// MEM-stage load/store bus between the pipeline and the data memory.
interface data_mem_ws_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: synchronous write, registered read; storage itself is never reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_rclr,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  // Read register holds between accesses; a rejected load clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rdata <= '0;
    else if (i_re)   r_rdata <= r_mem[i_idx];
    else if (i_rclr) r_rdata <= '0;
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_ws.sv
// Data memory with configurable wait states, range/alignment checking and a registered read path.
module data_mem_ws
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  data_mem_ws_if.slave bus
);
  localparam int unsigned BPW    = bytes_per_word(DATA_W);
  localparam int unsigned OFF_W  = clog2(BPW);
  localparam int unsigned IDX_W  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int unsigned WLOAD  = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
  localparam int unsigned WCNT_W = (clog2(WLOAD + 1) > 0) ? clog2(WLOAD + 1) : 1;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_op_w;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready;
  logic                r_err;

  logic                w_req;
  logic                w_idle;
  logic                w_acc;
  logic                w_op_w;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_off;
  logic [ADDR_W-1:0]   w_idx_full;
  logic [IDX_W-1:0]    w_idx;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;

  assign w_req  = bus.mem_r_en | bus.mem_w_en;
  assign w_idle = (r_state == IDLE);

  // With zero wait states the access fires on the accepting edge, so decode from live inputs in IDLE.
  assign w_acc   = ~rst & (((r_state == WAIT) && (r_wcnt == '0)) ||
                           ((WAIT_CYCLES == 0) && w_idle && w_req));
  assign w_addr  = w_idle ? bus.addr     : r_addr;
  assign w_op_w  = w_idle ? bus.mem_w_en : r_op_w;
  assign w_wdata = w_idle ? bus.wdata    : r_wdata;

  assign w_off      = w_addr - ADDR_W'(BASE_ADDR);
  assign w_idx_full = w_off >> OFF_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_err      = (w_addr < ADDR_W'(BASE_ADDR)) ||
                      (w_idx_full >= ADDR_W'(DEPTH)) ||
                      ((w_addr & ADDR_W'(BPW - 1)) != '0);

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_acc &  w_op_w & ~w_err),
    .i_re    (w_acc & ~w_op_w & ~w_err),
    .i_rclr  (w_acc & ~w_op_w &  w_err),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_op_w  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op_w  <= bus.mem_w_en;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            if (WAIT_CYCLES == 0) begin
              r_state <= DONE;
              r_ready <= 1'b1;
              r_err   <= w_err;
            end else begin
              r_state <= WAIT;
              r_wcnt  <= WCNT_W'(WLOAD);
            end
          end
        end
        WAIT: begin
          if (r_wcnt == '0) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_err   <= w_err;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = ~w_idle;
endmodule

// File: tb/tb_data_mem_ws.sv
// Directed bench: WAIT_CYCLES=2 instance driven from a vector table, WAIT_CYCLES=0 instance by hand.
module tb_data_mem_ws;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchecks = 0;
  int   nerr    = 0;

  always #5 clk = ~clk;

  data_mem_ws_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();
  data_mem_ws_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

  data_mem_ws #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  data_mem_ws #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; enables and address are scrambled after cycle 0.
  task automatic run_acc(input vec_t v, input int idx);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    bus2.mem_r_en = v.r;
    bus2.mem_w_en = v.w;
    bus2.addr     = v.addr;
    bus2.wdata    = v.wdata;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d busy c%0d", idx, c), 32'(bus2.busy), 32'd1);
      if (bus2.ready) begin
        seen = 1'b1;
        lat  = c;
        chk($sformatf("v%0d err", idx), 32'(bus2.err), 32'(v.exp_err));
        if (v.chk_rd) chk($sformatf("v%0d rdata", idx), bus2.rdata, v.exp_rd);
      end
      if (c == 1) begin
        bus2.mem_r_en = 1'b0;
        bus2.mem_w_en = 1'b0;
        bus2.addr     = 32'hFFFF_FFF0;
        bus2.wdata    = 32'h0BAD_0BAD;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'd3);
    @(negedge clk);
    chk($sformatf("v%0d ready after", idx), 32'(bus2.ready), 32'd0);
    chk($sformatf("v%0d busy after", idx), 32'(bus2.busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'd1276, 32'h1,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'd1280, 32'h2,        1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        1'b0, 1'b1, 32'h1};
    vecs[5]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'd1026, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, 1'b1, 32'd1036, 32'h5,        1'b0, 1'b1, 32'hA5A5A5A5};

    bus2.mem_r_en = 1'b0; bus2.mem_w_en = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    bus0.mem_r_en = 1'b0; bus0.mem_w_en = 1'b0; bus0.addr = '0; bus0.wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus2.ready), 32'd0);
    chk("rst err",   32'(bus2.err),   32'd0);
    chk("rst busy",  32'(bus2.busy),  32'd0);
    chk("rst rdata", bus2.rdata,      32'd0);
    chk("rst0 ready", 32'(bus0.ready), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_acc(vecs[i], i);

    // Second write to 1036 aborted by reset in cycle 1.
    @(negedge clk);
    bus2.mem_w_en = 1'b1;
    bus2.addr     = 32'd1036;
    bus2.wdata    = 32'h7;
    @(negedge clk);
    chk("abort busy pre", 32'(bus2.busy), 32'd1);
    bus2.mem_w_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("abort ready", 32'(bus2.ready), 32'd0);
    chk("abort err",   32'(bus2.err),   32'd0);
    chk("abort busy",  32'(bus2.busy),  32'd0);
    chk("abort rdata", bus2.rdata,      32'd0);
    #1 rst = 1'b0;
    run_acc('{1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, 1'b1, 32'h5}, 12);

    // Zero-wait instance: write held into DONE and turned into a read; read accepted two cycles on.
    @(negedge clk);
    bus0.mem_w_en = 1'b1;
    bus0.addr     = 32'd1028;
    bus0.wdata    = 32'h0000_1234;
    @(negedge clk);
    chk("ws0 c1 ready", 32'(bus0.ready), 32'd1);
    chk("ws0 c1 err",   32'(bus0.err),   32'd0);
    chk("ws0 c1 busy",  32'(bus0.busy),  32'd1);
    bus0.mem_w_en = 1'b0;
    bus0.mem_r_en = 1'b1;
    @(negedge clk);
    chk("ws0 c2 ready", 32'(bus0.ready), 32'd0);
    chk("ws0 c2 busy",  32'(bus0.busy),  32'd0);
    @(negedge clk);
    chk("ws0 c3 ready", 32'(bus0.ready), 32'd1);
    chk("ws0 c3 rdata", bus0.rdata,      32'h0000_1234);
    bus0.mem_r_en = 1'b0;
    bus0.addr     = 32'd1029;
    @(negedge clk);
    chk("ws0 c4 ready", 32'(bus0.ready), 32'd0);
    chk("ws0 c4 rdata hold", bus0.rdata, 32'h0000_1234);

    // Misaligned read on the zero-wait instance, request dropped after cycle 0.
    bus0.mem_r_en = 1'b1;
    @(negedge clk);
    bus0.mem_r_en = 1'b0;
    chk("ws0 mis ready", 32'(bus0.ready), 32'd1);
    chk("ws0 mis err",   32'(bus0.err),   32'd1);
    chk("ws0 mis rdata", bus0.rdata,      32'd0);
    @(negedge clk);
    chk("ws0 mis after", 32'(bus0.ready), 32'd0);
    chk("bpw const", 32'(BYTES_PER_WORD), 32'(dut2.BPW));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
